// File: rtl/cdb_arbiter_pkg.sv
// Shared system definitions for the completion broadcast path: the tag
// format carried on the CDB and the default sizing of the arbiter.
`ifndef CDB_NUM_SRC
`define CDB_NUM_SRC 4
`endif
`ifndef CDB_FIFO_DEPTH
`define CDB_FIFO_DEPTH 2
`endif

package cdb_arbiter_pkg;

   localparam int PHYS_REG_W         = 6;
   localparam int CDB_NUM_SRC_DEF    = `CDB_NUM_SRC;
   localparam int CDB_FIFO_DEPTH_DEF = `CDB_FIFO_DEPTH;

   typedef struct packed {
      logic [PHYS_REG_W-1:0] phys_reg;
      logic                  ready;
   } tag_t;

   // Physical register 0 is hard-wired; completions targeting it carry no news.
   function automatic logic tag_is_live(input tag_t t);
      return (t.phys_reg != {PHYS_REG_W{1'b0}});
   endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source completion queue: small circular buffer with registered count.
// Flush (pipeline interrupt) and reset both empty the queue at the edge.
module cdb_src_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic clock,
   input  logic reset,
   input  logic flush,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t head,
   output logic empty,
   output logic full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   tag_t             mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return {PTR_W{1'b0}};
      else                        return p + PTR_W'(1);
   endfunction

   assign empty   = (count == {CNT_W{1'b0}});
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush outranks any push or pop.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= {PTR_W{1'b0}};
         wr_ptr <= {PTR_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Tag storage; contents are only meaningful below the count.
   always_ff @(posedge clock) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completions per functional unit and
// broadcasts one tag per cycle, choosing sources round-robin.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = CDB_NUM_SRC_DEF,
   parameter int DEPTH   = CDB_FIFO_DEPTH_DEF
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       interrupt,
   input  logic [NUM_SRC-1:0]         fu_valid,
   input  tag_t [NUM_SRC-1:0]         fu_tag,
   output logic [NUM_SRC-1:0]         fu_ready,
   output tag_t                       cdb,
   output logic                       cdb_en,
   output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

   localparam int SRC_W = $clog2(NUM_SRC);

   tag_t [NUM_SRC-1:0] heads;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   grant;
   logic               any_pending;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clock    (clock),
         .reset    (reset),
         .flush    (interrupt),
         .push     (push[i]),
         .push_tag (fu_tag[i]),
         .pop      (pop[i]),
         .head     (heads[i]),
         .empty    (empty[i]),
         .full     (full[i])
      );
   end

   // Round-robin search for the first non-empty queue starting at rr_ptr.
   always_comb begin : grant_search
      int   idx;
      logic take;
      grant       = {SRC_W{1'b0}};
      any_pending = 1'b0;
      idx         = 0;
      take        = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx         = (int'(rr_ptr) + k) % NUM_SRC;
         take        = !any_pending && !empty[idx];
         grant       = take ? SRC_W'(idx) : grant;
         any_pending = any_pending || take;
      end
   end

   // Broadcast drive; the bus is held at zero whenever nothing is sent.
   always_comb begin
      cdb_en  = any_pending && !reset && !interrupt;
      cdb     = '0;
      cdb_src = {SRC_W{1'b0}};
      if (cdb_en) begin
         cdb       = heads[grant];
         cdb.ready = 1'b1;
         cdb_src   = grant;
      end else begin
         cdb       = '0;
         cdb_src   = {SRC_W{1'b0}};
      end
   end

   // Per-source handshake: zero-register completions are accepted then dropped.
   always_comb begin
      fu_ready = '0;
      push     = '0;
      pop      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         fu_ready[i] = reset ? 1'b1 : !full[i];
         push[i]     = fu_valid[i] && !full[i] && tag_is_live(fu_tag[i]);
         pop[i]      = cdb_en && (grant == SRC_W'(i));
      end
   end

   // Round-robin pointer moves just past the source that won the bus.
   always_ff @(posedge clock) begin
      if (reset || interrupt)
         rr_ptr <= {SRC_W{1'b0}};
      else if (cdb_en)
         rr_ptr <= (grant == SRC_W'(NUM_SRC - 1)) ? {SRC_W{1'b0}} : grant + SRC_W'(1);
      else
         rr_ptr <= rr_ptr;
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expected bus values.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       interrupt;
   logic [3:0] fu_valid;
   tag_t [3:0] fu_tag;
   logic [3:0] fu_ready;
   tag_t       cdb;
   logic       cdb_en;
   logic [1:0] cdb_src;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   cdb_arbiter #(.NUM_SRC(4), .DEPTH(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .interrupt (interrupt),
      .fu_valid  (fu_valid),
      .fu_tag    (fu_tag),
      .fu_ready  (fu_ready),
      .cdb       (cdb),
      .cdb_en    (cdb_en),
      .cdb_src   (cdb_src)
   );

   task automatic check_val(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input int t0, input int t1, input int t2, input int t3);
      fu_valid  = v;
      fu_tag[0] = '{phys_reg: 6'(t0), ready: 1'b0};
      fu_tag[1] = '{phys_reg: 6'(t1), ready: 1'b0};
      fu_tag[2] = '{phys_reg: 6'(t2), ready: 1'b0};
      fu_tag[3] = '{phys_reg: 6'(t3), ready: 1'b0};
   endtask

   // phys=0 means no broadcast expected this cycle
   task automatic expect_bus(input string name, input int phys, input int src, input int rdy);
      #2;
      check_val({name, ".en"},  int'(cdb_en),   (phys != 0) ? 1 : 0);
      check_val({name, ".cdb"}, int'(cdb),      (phys != 0) ? (phys * 2 + 1) : 0);
      check_val({name, ".src"}, int'(cdb_src),  src);
      check_val({name, ".rdy"}, int'(fu_ready), rdy);
   endtask

   // back-pressure table: source 0 streams, source 1 pushes three tags
   int bp_v0  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
   int bp_t0  [10] = '{40, 41, 42, 43, 43, 44, 44, 0, 0, 0};
   int bp_v1  [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
   int bp_t1  [10] = '{30, 31, 32, 32, 0, 0, 0, 0, 0, 0};
   int bp_ph  [10] = '{0, 40, 30, 41, 31, 42, 32, 43, 44, 0};
   int bp_src [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
   int bp_rdy [10] = '{15, 15, 13, 14, 13, 14, 15, 14, 15, 15};

   initial begin
      reset     = 1'b1;
      interrupt = 1'b0;
      drive(4'b0000, 0, 0, 0, 0);
      step();
      expect_bus("rst", 0, 0, 15);
      step();
      drive(4'b1111, 1, 2, 3, 4);
      expect_bus("rst_push", 0, 0, 15);
      step();
      reset = 1'b0;
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("post_rst", 0, 0, 15);

      // single source
      step();
      drive(4'b0100, 0, 0, 17, 0);
      expect_bus("single.req", 0, 0, 15);
      step();
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("single.bc", 17, 2, 15);
      step();
      expect_bus("single.idle", 0, 0, 15);

      // reset brings rr_ptr home before contention
      step();
      reset = 1'b1;
      expect_bus("rst2", 0, 0, 15);
      step();
      reset = 1'b0;
      drive(4'b1111, 5, 6, 7, 8);
      expect_bus("cont.req", 0, 0, 15);
      step();
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("cont.0", 5, 0, 15);
      step();
      expect_bus("cont.1", 6, 1, 15);
      step();
      expect_bus("cont.2", 7, 2, 15);
      step();
      expect_bus("cont.3", 8, 3, 15);
      step();
      drive(4'b1010, 0, 21, 0, 20);
      expect_bus("cont.idle", 0, 0, 15);
      step();
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("rr0.a", 21, 1, 15);
      step();
      expect_bus("rr0.b", 20, 3, 15);
      step();
      expect_bus("rr0.idle", 0, 0, 15);

      // back-pressure on source 1 against a streaming source 0
      for (int r = 0; r < 10; r++) begin
         step();
         drive({2'b00, 1'(bp_v1[r]), 1'(bp_v0[r])}, bp_t0[r], bp_t1[r], 0, 0);
         expect_bus($sformatf("bp%0d", r), bp_ph[r], bp_src[r], bp_rdy[r]);
      end

      // zero tag is accepted but never stored
      step();
      drive(4'b1000, 0, 0, 0, 0);
      expect_bus("zero.1", 0, 0, 15);
      step();
      expect_bus("zero.2", 0, 0, 15);
      step();
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("zero.after", 0, 0, 15);

      // flush with a same-cycle push on source 0 (rr_ptr is 1 here)
      step();
      drive(4'b1111, 50, 51, 52, 53);
      expect_bus("flush.p1", 0, 0, 15);
      step();
      drive(4'b1110, 0, 55, 56, 57);
      expect_bus("flush.p2", 51, 1, 15);
      step();
      interrupt = 1'b1;
      drive(4'b0001, 9, 0, 0, 0);
      expect_bus("flush.irq", 0, 0, 3);
      step();
      interrupt = 1'b0;
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("flush.after", 0, 0, 15);
      for (int r = 0; r < 6; r++) begin
         step();
         expect_bus($sformatf("flush.quiet%0d", r), 0, 0, 15);
      end

      // reset in the middle of traffic with three tags pending
      step();
      drive(4'b0111, 60, 61, 62, 0);
      expect_bus("mrst.p1", 0, 0, 15);
      step();
      drive(4'b1000, 0, 0, 0, 64);
      expect_bus("mrst.p2", 60, 0, 15);
      step();
      reset = 1'b1;
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("mrst.rst", 0, 0, 15);
      step();
      reset = 1'b0;
      expect_bus("mrst.after1", 0, 0, 15);
      step();
      expect_bus("mrst.after2", 0, 0, 15);
      step();
      drive(4'b1001, 3, 0, 0, 63);
      expect_bus("mrst.push", 0, 0, 15);
      step();
      drive(4'b0000, 0, 0, 0, 0);
      expect_bus("mrst.rr0", 3, 0, 15);
      step();
      expect_bus("mrst.rr1", 63, 3, 15);
      step();
      expect_bus("mrst.idle", 0, 0, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The module SHALL have the parameter NUM_SRC, default 4: number of completing functional-unit sources, indexed 0=mem, 1=branch, 2..NUM_SRC-1 = alu/mult.
REQ-002 The module SHALL have the parameter DEPTH, default 2: entries per source holding FIFO, minimum 1.
REQ-003 The module SHALL have the port clock  input  1  system clock, all state on posedge.
REQ-004 The module SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have the port interrupt  input  1  pipeline flush; discards all pending completions.
REQ-006 The module SHALL have the port fu_valid  input  NUM_SRC  per-source completion request.
REQ-007 The module SHALL have the port fu_tag  input  NUM_SRC x TAG  per-source destination tag; only phys_reg is used.
REQ-008 The module SHALL have the port fu_ready  output  NUM_SRC  per-source space available.
REQ-009 The module SHALL have the port cdb  output  TAG  broadcast tag; ready field 1 whenever cdb_en=1.
REQ-010 The module SHALL have the port cdb_en  output  1  broadcast valid this cycle.
REQ-011 The module SHALL have the port cdb_src  output  $clog2(NUM_SRC)  index of the source that owns the current broadcast.

Function
REQ-012 fu_ready[i] SHALL equal (count[i] < DEPTH), derived from registered count only; there is no same-cycle pop-to-push bypass.
REQ-013 A push SHALL occur on source i when fu_valid[i] && fu_ready[i]; the tag enters FIFO i at the next posedge.
REQ-014 A handshake carrying phys_reg==0 SHALL be accepted (fu_ready unaffected) but SHALL NOT be stored or broadcast.
REQ-015 The grant SHALL be combinational: the first non-empty FIFO searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
REQ-016 cdb_en SHALL be 1 iff any FIFO is non-empty and reset=0 and interrupt=0; cdb SHALL carry the granted head and cdb_src the granted index.
REQ-017 When cdb_en=0, cdb SHALL be driven all-zero and cdb_src SHALL be 0.
REQ-018 The granted head SHALL be popped at the posedge of every cycle with cdb_en=1; exactly one broadcast SHALL occur per cycle, and no tag SHALL be broadcast twice.
REQ-019 When cdb_en=1, rr_ptr SHALL become (granted+1) mod NUM_SRC; otherwise it SHALL hold.
REQ-020 Latency: a tag pushed at the edge ending cycle N SHALL broadcast no earlier than cycle N+1, and no later than N+1+(NUM_SRC*DEPTH-1) under full contention.
REQ-021 A push and a pop on the same FIFO in one cycle SHALL leave count unchanged, with ordering preserved (FIFO per source).
REQ-022 Per-source order SHALL be strictly FIFO; cross-source order is determined only by round-robin.
REQ-023 Interrupt SHALL take priority over push and pop: at the edge, all counts SHALL go to 0 and rr_ptr to 0, and any same-cycle push SHALL be dropped.

Reset
REQ-024 On reset, all FIFO counts, read/write pointers and rr_ptr SHALL go to 0.
REQ-025 While reset is high, outputs SHALL be cdb_en=0, cdb=0 and cdb_src=0, and fu_ready SHALL be all 1.
REQ-026 Reset asserted mid-traffic SHALL discard pending tags without broadcasting them.

Structure
REQ-027 TAG SHALL come from the shared sys_defs; CDB_NUM_SRC and CDB_FIFO_DEPTH SHALL be macros in sys_defs and serve as the parameter defaults.
REQ-028 The per-source queue SHALL be the sub-module cdb_src_fifo (push, pop, flush, head, empty, full), instantiated NUM_SRC times.
REQ-029 The round-robin grant and rr_ptr SHALL live in cdb_arbiter itself; no other sub-modules are permitted.

Verification
REQ-030 Single source: reset, then fu_valid[2]=1 with phys_reg=17 for one cycle -> next cycle cdb_en=1, cdb.phys_reg=17, cdb.ready=1, cdb_src=2; the cycle after, cdb_en=0.
REQ-031 Contention: all 4 sources push at once (tags 5,6,7,8), rr_ptr=0 -> broadcasts 5,6,7,8 on consecutive cycles with cdb_src 0,1,2,3, then rr_ptr=0.
REQ-032 Back-pressure: source 1 pushes 3 tags back-to-back while source 0 streams continuously -> fu_ready[1]=0 after 2 accepted; third tag accepted only after pop; source-1 order preserved; sources alternate 0,1.
REQ-033 Zero tag: push phys_reg=0 on source 3 -> handshake completes, cdb_en stays 0, count[3] stays 0.
REQ-034 Flush: fill all FIFOs, assert interrupt for one cycle while source 0 also pushes tag 9 -> cdb_en=0 that cycle; afterwards all fu_ready=1 and no broadcasts, and tag 9 is never seen.
REQ-035 Mid-operation reset: with 3 tags pending, assert reset for one cycle -> cdb_en=0 during reset and afterwards, and rr_ptr=0.
